brushless_commutator: RTL and testbench
=======================================

Name: brushless_commutator

Overview:
- Commutation stage directly upstream of the motor drive block. It turns three asynchronous hall-sensor inputs, a drive magnitude and a brake request into the per-phase select codes (selGrn/selYlw/selBlu) and the 11-bit PWM duty that the drive block consumes.
- Hall sampling is aligned to the drive block's PWM_synch pulse, so commutation never changes mid PWM period.
- Also provides stall detection, a hall-error flag and a commutation counter for the motor controller.

Parameters:
STALL_PERIODS, 64, number of consecutive PWM periods with no hall change (while driving) before stall asserts
CNT_W, 16, width of commutation counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
hGrn  input  1  green hall sensor, asynchronous
hYlw  input  1  yellow hall sensor, asynchronous
hBlu  input  1  blue hall sensor, asynchronous
PWM_synch  input  1  one-clk pulse per PWM period, from drive block
drv_mag  input  12  unsigned drive magnitude
brake_n  input  1  active-low brake request, synchronous
duty  output  11  PWM duty to drive block
selGrn  output  2  green phase select
selYlw  output  2  yellow phase select
selBlu  output  2  blue phase select
hall_err  output  1  last captured hall code was illegal
stall  output  1  rotor stalled while driving
comm_cnt  output  CNT_W  count of legal hall transitions, wraps

Behaviour:
- Select encoding: 00 = HiZ; 01 = rev_curr (high=~PWM, low=PWM); 10 = frwrd_curr (high=PWM, low=~PWM); 11 = brake (high=0, low=PWM).
- Reset values: all outputs 0; hall sync flops 0; rot_state 3'b000; period counter 0.
- Sync: each hall input passes through a 2-flop synchronizer giving hall_sync = {G,Y,B}.
- Capture: on a clk where PWM_synch=1, rot_state <= hall_sync. rot_state holds at all other clks.
- Commutation table for rot_state -> {Grn,Ylw,Blu}:
  - 101 -> frwrd, rev, HiZ
  - 100 -> frwrd, HiZ, rev
  - 110 -> HiZ, frwrd, rev
  - 010 -> rev, frwrd, HiZ
  - 011 -> rev, HiZ, frwrd
  - 001 -> HiZ, rev, frwrd
  - 000/111 -> all HiZ
- Brake: brake_n=0 forces all sel = 11, independent of rot_state.
- Duty:
  - brake_n=0: duty = 11'h600.
  - Otherwise: duty = 11'h400 + drv_mag[11:2], range 0x400..0x7FF, no overflow.
- Output registers: sel*, duty registered, recomputed every clk from current rot_state/brake_n/drv_mag. Latency is 1 clk after rot_state or input change.
- Hall change to sel change: ≤ 2 sync clks + wait for next PWM_synch + 1 clk.
- hall_err: updated only on capture clks. Set if the captured code is 000 or 111; cleared on capture of a legal code.
- comm_cnt: +1 (mod 2^CNT_W) on a capture clk where the captured code is legal and differs from the previous rot_state. Not counted when the previous rot_state was illegal (e.g. first code after reset).
- Stall period counter:
  - On a capture clk: cleared if the captured code differs from rot_state; otherwise +1, saturating at STALL_PERIODS.
  - Cleared while brake_n=0 or drv_mag=0.
- stall (registered): 1 when counter == STALL_PERIODS and brake_n=1 and drv_mag!=0; deasserts 1 clk after the counter clears.
- Simultaneous hall change and PWM_synch: synchronizer value at that clk is captured; the new edge is picked up on the following period.
- brake_n toggling mid PWM period: sel/duty follow next clk; the drive block's flops absorb it.
- Async reset mid-operation: all state to reset values immediately; sel = HiZ, duty = 0 until the first clk after release.

Test Plan:
- Reset, then release with halls=101, drv_mag=0, brake_n=1, PWM_synch pulse at t0 -> at t0+1 sel={10,01,00}, duty=0x400, hall_err=0, comm_cnt=0.
- Step halls through 101->100->110->010->011->001, one PWM_synch after each change -> sel follows the table each step, comm_cnt=5, stall=0.
- drv_mag=12'hFFF, no brake -> duty=0x7FF. drv_mag=12'h004 -> duty=0x401.
- Drop brake_n to 0 mid period -> next clk all sel=11, duty=0x600. Raise brake_n -> table resumes next clk.
- Halls=111 captured -> hall_err=1, all sel=00. Next capture with 001 -> hall_err=0, comm_cnt unchanged.
- STALL_PERIODS=4, drv_mag=12'h100, halls held constant -> stall=1 one clk after 4th identical capture. A hall change plus capture clears stall next clk. Setting drv_mag=0 also clears stall.

Source files
------------

// File: rtl/brushless_commutator_if.sv
// Signal bundle between the motor controller / drive block and the commutator.
// The controller side (master) supplies halls, timing and drive requests;
// the commutator (slave) returns phase selects, duty and status.
interface brushless_commutator_if #(
    parameter int CNT_W = 16
);
    logic             hGrn;
    logic             hYlw;
    logic             hBlu;
    logic             PWM_synch;
    logic [11:0]      drv_mag;
    logic             brake_n;
    logic [10:0]      duty;
    logic [1:0]       selGrn;
    logic [1:0]       selYlw;
    logic [1:0]       selBlu;
    logic             hall_err;
    logic             stall;
    logic [CNT_W-1:0] comm_cnt;

    modport master (
        output hGrn, hYlw, hBlu, PWM_synch, drv_mag, brake_n,
        input  duty, selGrn, selYlw, selBlu, hall_err, stall, comm_cnt
    );

    modport slave (
        input  hGrn, hYlw, hBlu, PWM_synch, drv_mag, brake_n,
        output duty, selGrn, selYlw, selBlu, hall_err, stall, comm_cnt
    );
endinterface

// File: rtl/brushless_commutator.sv
// Brushless motor commutation stage: synchronises the hall sensors, captures the
// rotor position once per PWM period and produces registered phase selects and
// PWM duty for the drive block, plus hall-error, stall and commutation count.
module brushless_commutator #(
    parameter int STALL_PERIODS = 64,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    brushless_commutator_if.slave bus
);

    // Phase select codes understood by the drive block.
    typedef enum logic [1:0] {
        SEL_HIZ = 2'b00,
        SEL_REV = 2'b01,
        SEL_FWD = 2'b10,
        SEL_BRK = 2'b11
    } sel_e;

    localparam int                 STALL_W   = $clog2(STALL_PERIODS + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_PERIODS);

    logic [2:0]         r_hall_meta;
    logic [2:0]         r_hall_sync;
    logic [2:0]         r_rot_state;
    logic               r_hall_err;
    logic [CNT_W-1:0]   r_comm_cnt;
    logic [STALL_W-1:0] r_period_cnt;
    logic               r_stall;
    sel_e               r_sel_grn;
    sel_e               r_sel_ylw;
    sel_e               r_sel_blu;
    logic [10:0]        r_duty;

    sel_e               w_sel_grn;
    sel_e               w_sel_ylw;
    sel_e               w_sel_blu;
    logic [10:0]        w_duty;
    logic               w_capture;
    logic               w_new_legal;
    logic               w_old_legal;
    logic               w_changed;
    logic               w_driving;
    logic [1:0]         w_unused_mag_lsbs;

    assign w_capture   = bus.PWM_synch;
    assign w_new_legal = (r_hall_sync != 3'b000) && (r_hall_sync != 3'b111);
    assign w_old_legal = (r_rot_state != 3'b000) && (r_rot_state != 3'b111);
    assign w_changed   = (r_hall_sync != r_rot_state);
    assign w_driving   = bus.brake_n && (bus.drv_mag != 12'h000);

    // Duty resolution is 10 bits of magnitude, so the two LSBs are dropped.
    assign w_unused_mag_lsbs = bus.drv_mag[1:0];

    // Two-flop synchronizer for the asynchronous hall inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hall_meta <= 3'b000;
            r_hall_sync <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments let the second stage take the first
            // stage's old value; blocking here would collapse the chain to one flop.
            r_hall_meta <= {bus.hGrn, bus.hYlw, bus.hBlu};
            r_hall_sync <= r_hall_meta;
        end
    end

    // Rotor position, hall error and commutation count update only on PWM_synch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rot_state <= 3'b000;
            r_hall_err  <= 1'b0;
            r_comm_cnt  <= '0;
        end else if (w_capture) begin
            r_rot_state <= r_hall_sync;
            r_hall_err  <= !w_new_legal;
            if (w_new_legal && w_old_legal && w_changed) begin
                r_comm_cnt <= r_comm_cnt + CNT_W'(1);
            end
        end
    end

    // Count PWM periods without hall movement while driving; saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_stall      <= 1'b0;
        end else begin
            if (!w_driving) begin
                r_period_cnt <= '0;
            end else if (w_capture) begin
                if (w_changed) begin
                    r_period_cnt <= '0;
                end else if (r_period_cnt != STALL_MAX) begin
                    r_period_cnt <= r_period_cnt + STALL_W'(1);
                end
            end
            r_stall <= (r_period_cnt == STALL_MAX) && w_driving;
        end
    end

    // Commutation table, brake override and duty computation.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_sel_grn = SEL_HIZ;
        w_sel_ylw = SEL_HIZ;
        w_sel_blu = SEL_HIZ;
        w_duty    = 11'h400 + {1'b0, bus.drv_mag[11:2]};
        if (!bus.brake_n) begin
            w_sel_grn = SEL_BRK;
            w_sel_ylw = SEL_BRK;
            w_sel_blu = SEL_BRK;
            w_duty    = 11'h600;
        end else begin
            case (r_rot_state)
                3'b101: begin w_sel_grn = SEL_FWD; w_sel_ylw = SEL_REV; end
                3'b100: begin w_sel_grn = SEL_FWD; w_sel_blu = SEL_REV; end
                3'b110: begin w_sel_ylw = SEL_FWD; w_sel_blu = SEL_REV; end
                3'b010: begin w_sel_grn = SEL_REV; w_sel_ylw = SEL_FWD; end
                3'b011: begin w_sel_grn = SEL_REV; w_sel_blu = SEL_FWD; end
                3'b001: begin w_sel_ylw = SEL_REV; w_sel_blu = SEL_FWD; end
                default: ;
            endcase
        end
    end

    // Register selects and duty so the drive block sees glitch-free codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_grn <= SEL_HIZ;
            r_sel_ylw <= SEL_HIZ;
            r_sel_blu <= SEL_HIZ;
            r_duty    <= 11'h000;
        end else begin
            r_sel_grn <= w_sel_grn;
            r_sel_ylw <= w_sel_ylw;
            r_sel_blu <= w_sel_blu;
            r_duty    <= w_duty;
        end
    end

    assign bus.selGrn   = r_sel_grn;
    assign bus.selYlw   = r_sel_ylw;
    assign bus.selBlu   = r_sel_blu;
    assign bus.duty     = r_duty;
    assign bus.hall_err = r_hall_err;
    assign bus.stall    = r_stall;
    assign bus.comm_cnt = r_comm_cnt;

endmodule

// File: tb/tb_brushless_commutator.sv
// Directed self-checking bench for brushless_commutator: a table of hall /
// drive vectors with hand-computed outputs, then hand-written sequences for
// brake timing, stall detection, capture races and async reset.
module tb_brushless_commutator;

    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    brushless_commutator_if #(.CNT_W(CNT_W)) bus ();

    brushless_commutator #(
        .STALL_PERIODS (4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [2:0]  halls;
        logic [11:0] mag;
        logic        brake_n;
        logic [1:0]  e_g;
        logic [1:0]  e_y;
        logic [1:0]  e_b;
        logic [10:0] e_duty;
        logic        e_err;
        logic        e_stall;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input logic [1:0] y,
                             input logic [1:0] b, input logic [10:0] d, input logic err,
                             input logic stl, input logic [15:0] cnt);
        check({tag, ".sel"}, {26'd0, bus.selGrn, bus.selYlw, bus.selBlu}, {26'd0, g, y, b});
        check({tag, ".duty"}, {21'd0, bus.duty}, {21'd0, d});
        check({tag, ".hall_err"}, {31'd0, bus.hall_err}, {31'd0, err});
        check({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, stl});
        check({tag, ".comm_cnt"}, {16'd0, bus.comm_cnt}, {16'd0, cnt});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_halls(input logic [2:0] code);
        {bus.hGrn, bus.hYlw, bus.hBlu} = code;
        tick();
        tick();
    endtask

    task automatic capture();
        bus.PWM_synch = 1'b1;
        tick();
        bus.PWM_synch = 1'b0;
    endtask

    initial begin
        //             halls    mag      brk   G      Y      B      duty    err   stl   cnt
        vecs[0]  = '{3'b101, 12'h000, 1'b1, 2'b10, 2'b01, 2'b00, 11'h400, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{3'b100, 12'h000, 1'b1, 2'b10, 2'b00, 2'b01, 11'h400, 1'b0, 1'b0, 16'd1};
        vecs[2]  = '{3'b110, 12'h000, 1'b1, 2'b00, 2'b10, 2'b01, 11'h400, 1'b0, 1'b0, 16'd2};
        vecs[3]  = '{3'b010, 12'h000, 1'b1, 2'b01, 2'b10, 2'b00, 11'h400, 1'b0, 1'b0, 16'd3};
        vecs[4]  = '{3'b011, 12'h000, 1'b1, 2'b01, 2'b00, 2'b10, 11'h400, 1'b0, 1'b0, 16'd4};
        vecs[5]  = '{3'b001, 12'hFFF, 1'b1, 2'b00, 2'b01, 2'b10, 11'h7FF, 1'b0, 1'b0, 16'd5};
        vecs[6]  = '{3'b001, 12'h004, 1'b1, 2'b00, 2'b01, 2'b10, 11'h401, 1'b0, 1'b0, 16'd5};
        vecs[7]  = '{3'b111, 12'h123, 1'b1, 2'b00, 2'b00, 2'b00, 11'h448, 1'b1, 1'b0, 16'd5};
        vecs[8]  = '{3'b001, 12'h000, 1'b1, 2'b00, 2'b01, 2'b10, 11'h400, 1'b0, 1'b0, 16'd5};
        vecs[9]  = '{3'b101, 12'h803, 1'b1, 2'b10, 2'b01, 2'b00, 11'h600, 1'b0, 1'b0, 16'd6};
        vecs[10] = '{3'b000, 12'h000, 1'b1, 2'b00, 2'b00, 2'b00, 11'h400, 1'b1, 1'b0, 16'd6};
        vecs[11] = '{3'b000, 12'h000, 1'b0, 2'b11, 2'b11, 2'b11, 11'h600, 1'b1, 1'b0, 16'd6};
        vecs[12] = '{3'b101, 12'h000, 1'b1, 2'b10, 2'b01, 2'b00, 11'h400, 1'b0, 1'b0, 16'd6};

        rst_n         = 1'b0;
        bus.hGrn      = 1'b0;
        bus.hYlw      = 1'b0;
        bus.hBlu      = 1'b0;
        bus.PWM_synch = 1'b0;
        bus.drv_mag   = 12'h000;
        bus.brake_n   = 1'b1;

        // Reset state, checked away from clock edges.
        #22;
        check_all("reset", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;

        // Table: each vector is synchronised, captured on PWM_synch, then one clk to outputs.
        for (int i = 0; i < 13; i++) begin
            bus.drv_mag = vecs[i].mag;
            bus.brake_n = vecs[i].brake_n;
            set_halls(vecs[i].halls);
            capture();
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_g, vecs[i].e_y, vecs[i].e_b,
                      vecs[i].e_duty, vecs[i].e_err, vecs[i].e_stall, vecs[i].e_cnt);
        end

        // Brake toggled mid period, no PWM_synch involved.
        bus.drv_mag = 12'h100;
        tick();
        check("brk.duty_pre", {21'd0, bus.duty}, {21'd0, 11'h440});
        bus.brake_n = 1'b0;
        tick();
        check_all("brk.on", 2'b11, 2'b11, 2'b11, 11'h600, 1'b0, 1'b0, 16'd6);
        bus.brake_n = 1'b1;
        tick();
        check_all("brk.off", 2'b10, 2'b01, 2'b00, 11'h440, 1'b0, 1'b0, 16'd6);

        // Stall: four identical captures while driving.
        for (int k = 1; k <= 4; k++) capture();
        check("stall.cap4_edge", {31'd0, bus.stall}, 32'd0);
        tick();
        check("stall.set", {31'd0, bus.stall}, 32'd1);

        // Counter saturates rather than wrapping.
        for (int k = 0; k < 4; k++) capture();
        tick();
        check("stall.saturate", {31'd0, bus.stall}, 32'd1);

        // Hall change with capture clears stall one clk later.
        set_halls(3'b100);
        capture();
        check("stall.chg_edge", {31'd0, bus.stall}, 32'd1);
        tick();
        check_all("stall.cleared", 2'b10, 2'b00, 2'b01, 11'h440, 1'b0, 1'b0, 16'd7);

        // Re-stall, then drv_mag=0 clears it.
        for (int k = 0; k < 4; k++) capture();
        tick();
        check("stall.reset2", {31'd0, bus.stall}, 32'd1);
        bus.drv_mag = 12'h000;
        tick();
        check("stall.mag0", {31'd0, bus.stall}, 32'd0);
        check("stall.mag0_duty", {21'd0, bus.duty}, {21'd0, 11'h400});

        // Hall edge coincident with PWM_synch: old synchronised code is captured.
        bus.drv_mag = 12'h100;
        {bus.hGrn, bus.hYlw, bus.hBlu} = 3'b110;
        capture();
        tick();
        check_all("race.old", 2'b10, 2'b00, 2'b01, 11'h440, 1'b0, 1'b0, 16'd7);
        capture();
        tick();
        check_all("race.new", 2'b00, 2'b10, 2'b01, 11'h440, 1'b0, 1'b0, 16'd8);

        // Async reset mid-operation.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_all("areset", 2'b00, 2'b00, 2'b00, 11'h000, 1'b0, 1'b0, 16'd0);
        #1 rst_n = 1'b1;
        #1;
        check("areset.rel_duty", {21'd0, bus.duty}, 32'd0);
        tick();
        check_all("areset.clk1", 2'b00, 2'b00, 2'b00, 11'h440, 1'b0, 1'b0, 16'd0);
        tick();
        capture();
        tick();
        check_all("areset.first", 2'b00, 2'b10, 2'b01, 11'h440, 1'b0, 1'b0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
